wb_dram_responder: RTL and testbench
====================================

// Module: wb_dram_responder
// PURPOSE
//  Wishbone B4 responder (target end) for the ZAP CPU's bus: backs DRAM/BIOS-style memory with an internal word RAM.
//  Sits where the top level routes non-MADAM/CLIO traffic; replaces the sim-C data path.
//  Supports classic cycles, programmable wait states and CTI/BTE incrementing bursts.
// PARAMETERS
//  AW          20            word-address width; RAM depth = 2**AW x 32 bits
//  BASE_ADDR   32'h00000000  byte base of region; valid when adr[31:AW+2]==BASE_ADDR[31:AW+2]
//  WAIT_STATES 1             extra cycles before the first ack of any cycle (0..15)
// PORTS
//  sys_clk     in   1   single clock, all logic rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  i_wb_adr    in   32  byte address (bits [1:0] ignored)
//  i_wb_dat    in   32  write data
//  i_wb_sel    in   4   byte lane enables
//  i_wb_we     in   1   1=write
//  i_wb_cyc    in   1   bus cycle active
//  i_wb_stb    in   1   strobe
//  i_wb_cti    in   3   000 classic, 010 incrementing burst, 111 end-of-burst
//  i_wb_bte    in   2   00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  o_wb_dat    out  32  read data, valid while o_wb_ack=1
//  o_wb_ack    out  1   transfer acknowledge, registered
//  o_busy      out  1   1 when FSM not IDLE
// BEHAVIOUR
//  Reset: o_wb_ack=0, o_wb_dat=0, o_busy=0, FSM=IDLE, wait counter=0; RAM contents not cleared.
//  FSM IDLE: on cyc&stb sample adr into beat pointer, we/sel/cti/bte; cnt=WAIT_STATES; -> WAIT (cnt>0) or ACK.
//  WAIT: cnt decrements each cycle; at cnt==0 -> ACK. cyc=0 at any time -> IDLE, no write.
//  ACK: o_wb_ack=1 for exactly one cycle; read data = RAM[ptr]; write applied same edge per i_wb_sel lanes.
//   classic (cti 000) or cti 111 -> IDLE (ack drops next cycle even if stb still high).
//   cti 010 -> BURST, ptr advanced.
//  BURST: ack every cycle where cyc&stb=1 (zero wait states after first beat); stb=0 with cyc=1 -> hold, no ack, ptr held.
//   Beat with cti=111 acked, then IDLE. cyc=0 -> IDLE immediately, no ack.
//   Master's adr ignored after first beat; ptr update: linear +1; wrapN: ptr[log2N-1:0]+1 mod N, upper bits kept.
//   Linear wrap at 2**AW-1 -> 0.
//  Read data for next beat prefetched so burst throughput is 1 word/cycle; o_wb_dat holds last value when ack=0.
//  Out-of-range address (region mismatch): read returns 32'h0, write discarded, ack timing unchanged.
//  Writes with sel=4'b0000 acked, RAM unchanged.
//  reset_n low mid-cycle: ack and busy drop asynchronously; in-flight write not performed unless ack edge already occurred.
// CONFIGURATION
//  WB_DRAM_ERR_EN defined: adds port o_wb_err (out, 1, reset 0); out-of-range access asserts o_wb_err instead of
//   o_wb_ack with identical timing, then FSM -> IDLE (burst terminated). Undefined: no o_wb_err port, behaviour as above.
// TESTING
//  1 WAIT_STATES=1: write 0xDEADBEEF sel=1111 to 0x100, read 0x100 -> ack 2 cycles after stb, data 0xDEADBEEF.
//  2 Byte lanes: write 0x11223344 then sel=0010 data 0x0000AA00 -> read returns 0x1122AA44.
//  3 Read burst cti=010 bte=01 start 0x108, 4 beats, last cti=111 -> words 0x108,0x10C,0x100,0x104, acks consecutive.
//  4 Burst with stb low 2 cycles mid-stream -> no ack during gap, next beat resumes correct address, no skipped word.
//  5 cyc dropped during WAIT on write -> no ack, RAM unchanged, o_busy=0 next cycle.
//  6 Read 0x7FFFFFFC out of range -> data 0, ack; with WB_DRAM_ERR_EN -> o_wb_err=1, o_wb_ack=0.

Source files
------------

// File: rtl/wb_dram_responder.sv
// Wishbone B4 target backed by an internal word RAM (DRAM/BIOS region).
// Ports: sys_clk, reset_n (async, active-low); i_wb_adr/dat/sel/we/cyc/stb/cti/bte
// in; o_wb_dat/o_wb_ack out; o_busy (FSM not idle). Optional o_wb_err when the
// WB_DRAM_ERR_EN macro is defined (out-of-range access errors instead of acks).
module wb_dram_responder #(
  parameter int          AW          = 20,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic [2:0]  i_wb_cti,
  input  logic [1:0]  i_wb_bte,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
`ifdef WB_DRAM_ERR_EN
  output logic        o_wb_err,
`endif
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACK, S_BURST
  } state_e;

  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [3:0] WS      = 4'(WAIT_STATES);

  logic [31:0]   mem [2**AW];

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic          rng_q, rng_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q;
`ifdef WB_DRAM_ERR_EN
  logic          err_q, err_d;
`endif

  // Per-beat view: the first beat with zero wait states uses live bus
  // signals, every other beat uses the latched ones.
  logic          beat, cont;
  logic [AW-1:0] b_ptr, nxt_ptr, wmask;
  logic          b_we, b_rng;
  logic [3:0]    b_sel;
  logic [1:0]    b_bte;

  logic [AW-1:0] adr_ptr;
  logic          adr_rng;

  assign adr_ptr = i_wb_adr[AW+1:2];
  assign adr_rng = (i_wb_adr >> (AW + 2)) == (BASE_ADDR >> (AW + 2));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    rng_d   = rng_q;
    beat    = 1'b0;
    cont    = 1'b0;
    b_ptr   = ptr_q;
    b_we    = we_q;
    b_sel   = sel_q;
    b_bte   = bte_q;
    b_rng   = rng_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          ptr_d = adr_ptr;
          we_d  = i_wb_we;
          sel_d = i_wb_sel;
          cti_d = i_wb_cti;
          bte_d = i_wb_bte;
          rng_d = adr_rng;
          cnt_d = WS;
          if (WS == 4'd0) begin
            beat  = 1'b1;
            cont  = i_wb_cti == CTI_INC;
            b_ptr = adr_ptr;
            b_we  = i_wb_we;
            b_sel = i_wb_sel;
            b_bte = i_wb_bte;
            b_rng = adr_rng;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          beat = 1'b1;
          cont = cti_q == CTI_INC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Ack is on the bus this cycle; the master's request is still
      // visible, so it must not start a new cycle.
      S_ACK: state_d = S_IDLE;
      S_BURST: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (i_wb_stb) begin
          beat  = 1'b1;
          cont  = i_wb_cti == CTI_INC;
          b_sel = i_wb_sel;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (b_bte)
      2'b01:   wmask = AW'(3);
      2'b10:   wmask = AW'(7);
      2'b11:   wmask = AW'(15);
      default: wmask = '1;
    endcase
    nxt_ptr = (b_ptr & ~wmask) | ((b_ptr + AW'(1)) & wmask);

`ifdef WB_DRAM_ERR_EN
    ack_d = beat && b_rng;
    err_d = beat && !b_rng;
`else
    ack_d = beat;
`endif
    if (beat) begin
      ptr_d   = nxt_ptr;
      cnt_d   = '0;
      state_d = (cont && ack_d) ? S_BURST : S_ACK;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cti_q   <= '0;
      bte_q   <= '0;
      rng_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
`ifdef WB_DRAM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      rng_q   <= rng_d;
      ack_q   <= ack_d;
`ifdef WB_DRAM_ERR_EN
      err_q   <= err_d;
`endif
      if (beat) begin
        dat_q <= b_rng ? mem[b_ptr] : '0;
      end
    end
  end

  // RAM is not cleared by reset.
  always_ff @(posedge sys_clk) begin
    if (reset_n && beat && b_we && b_rng) begin
      for (int b = 0; b < 4; b++) begin
        if (b_sel[b]) begin
          mem[b_ptr][8*b +: 8] <= i_wb_dat[8*b +: 8];
        end
      end
    end
  end

  assign o_wb_dat = dat_q;
  assign o_wb_ack = ack_q;
  assign o_busy   = state_q != S_IDLE;
`ifdef WB_DRAM_ERR_EN
  assign o_wb_err = err_q;
`endif

endmodule

// File: tb/tb_wb_dram_responder.sv
// Directed bench for wb_dram_responder (AW=10, WAIT_STATES=1).
// Classic, byte-lane, wrap/linear burst, gap, abort, range and reset cases.
module tb_wb_dram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdat;
  logic        ack, busy, errw;
`ifdef WB_DRAM_ERR_EN
  logic        err;
  assign errw = err;
`else
  assign errw = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] bd [8];
  int          bt [8];
  int          bn, bsp;

  wb_dram_responder #(
    .AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)
  ) dut (
    .sys_clk(clk), .reset_n(rst_n),
    .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_cti(cti), .i_wb_bte(bte),
    .o_wb_dat(rdat), .o_wb_ack(ack),
`ifdef WB_DRAM_ERR_EN
    .o_wb_err(err),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic single(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat,
                        output logic ga, output logic ge);
    we = w; adr = a; wdat = d; sel = s;
    cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    lat = -1; rd = '0; ga = 1'b0; ge = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ack || errw) begin
        lat = c; rd = rdat; ga = ack; ge = errw;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic burst_read(input logic [31:0] a, input logic [1:0] b,
                            input int nb, input int gap_after,
                            input int gap_len);
    logic sp;
    int   gap;
    gap = 0; bn = 0; bsp = 0;
    we = 1'b0; adr = a; sel = 4'hF; bte = b;
    cti = (nb == 1) ? 3'b111 : 3'b010;
    cyc = 1'b1; stb = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      sp = stb;
      @(posedge clk); #1;
      if (ack) begin
        if (!sp) bsp++;
        bd[bn] = rdat; bt[bn] = c; bn++;
      end
      if (bn == nb) break;
      if (bn == gap_after && gap < gap_len) begin
        stb = 1'b0; gap++;
      end else begin
        stb = 1'b1;
      end
      if (bn == nb - 1) cti = 3'b111;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    adr = '0; wdat = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b want 0", ack);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (rdat !== 32'h0) begin
      errors++; $display("FAIL reset_dat: got %h want 0", rdat);
    end
`ifdef WB_DRAM_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", err);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int          lat;
    logic        a, e;
    single(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, rd, lat, a, e);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL single_wr_lat: got %0d want 2", lat);
    end
    single(1'b0, 32'h100, 32'h0, 4'hF, rd, lat, a, e);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL single_rd_lat: got %0d want 2", lat);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_rd_dat: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    int          lat;
    logic        a, e;
    single(1'b1, 32'h104, 32'h1122_3344, 4'hF, rd, lat, a, e);
    single(1'b1, 32'h104, 32'h0000_AA00, 4'b0010, rd, lat, a, e);
    single(1'b0, 32'h104, 32'h0, 4'hF, rd, lat, a, e);
    checks++;
    if (rd !== 32'h1122_AA44) begin
      errors++; $display("FAIL lane_merge: got %h want 1122aa44", rd);
    end
    single(1'b1, 32'h104, 32'hFFFF_FFFF, 4'b0000, rd, lat, a, e);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL sel0_lat: got %0d want 2", lat);
    end
    single(1'b0, 32'h104, 32'h0, 4'hF, rd, lat, a, e);
    checks++;
    if (rd !== 32'h1122_AA44) begin
      errors++; $display("FAIL sel0_keep: got %h want 1122aa44", rd);
    end
  endtask

  task automatic test_wrap_burst();
    logic [31:0] rd, exp [4];
    int          lat;
    logic        a, e;
    for (int i = 0; i < 4; i++) begin
      single(1'b1, 32'h100 + 32'(4*i), 32'hC0DE_0100 + 32'(4*i),
             4'hF, rd, lat, a, e);
    end
    exp[0] = 32'hC0DE_0108; exp[1] = 32'hC0DE_010C;
    exp[2] = 32'hC0DE_0100; exp[3] = 32'hC0DE_0104;
    burst_read(32'h108, 2'b01, 4, 0, 0);
    checks++;
    if (bn !== 4) begin
      errors++; $display("FAIL wrap_beats: got %0d want 4", bn);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < bn) begin
        checks++;
        if (bd[i] !== exp[i]) begin
          errors++;
          $display("FAIL wrap_dat%0d: got %h want %h", i, bd[i], exp[i]);
        end
      end
    end
    checks++;
    if (bn == 4 && bt[3] - bt[0] !== 3) begin
      errors++; $display("FAIL wrap_consec: got span %0d want 3",
                         bt[3] - bt[0]);
    end
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wrap_end: got ack=%b busy=%b want 0 0",
                         ack, busy);
    end
  endtask

  task automatic test_burst_gap();
    burst_read(32'h100, 2'b00, 4, 1, 2);
    checks++;
    if (bn !== 4) begin
      errors++; $display("FAIL gap_beats: got %0d want 4", bn);
    end
    checks++;
    if (bsp !== 0) begin
      errors++; $display("FAIL gap_noack: got %0d acks want 0", bsp);
    end
    checks++;
    if (bn == 4 && (bt[0] !== 2 || bt[1] !== 5 || bt[3] !== 7)) begin
      errors++; $display("FAIL gap_timing: got %0d %0d %0d want 2 5 7",
                         bt[0], bt[1], bt[3]);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < bn) begin
        checks++;
        if (bd[i] !== 32'hC0DE_0100 + 32'(4*i)) begin
          errors++; $display("FAIL gap_dat%0d: got %h want %h", i, bd[i],
                             32'hC0DE_0100 + 32'(4*i));
        end
      end
    end
  endtask

  task automatic test_linear_wrap();
    logic [31:0] rd;
    int          lat;
    logic        a, e;
    single(1'b1, 32'hFFC, 32'hC0DE_0FFC, 4'hF, rd, lat, a, e);
    single(1'b1, 32'h000, 32'hC0DE_0000, 4'hF, rd, lat, a, e);
    burst_read(32'hFFC, 2'b00, 2, 0, 0);
    checks++;
    if (bn !== 2 || bd[0] !== 32'hC0DE_0FFC || bd[1] !== 32'hC0DE_0000)
    begin
      errors++; $display("FAIL lin_wrap: got n=%0d %h %h want 2 c0de0ffc c0de0000",
                         bn, bd[0], bd[1]);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int          lat;
    logic        a, e;
    single(1'b1, 32'h110, 32'h5555_5555, 4'hF, rd, lat, a, e);
    we = 1'b1; adr = 32'h110; wdat = 32'hFFFF_FFFF; sel = 4'hF;
    cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got %b want 1", busy);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got ack=%b busy=%b want 0 0",
                         ack, busy);
    end
    single(1'b0, 32'h110, 32'h0, 4'hF, rd, lat, a, e);
    checks++;
    if (rd !== 32'h5555_5555) begin
      errors++; $display("FAIL abort_ram: got %h want 55555555", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int          lat;
    logic        a, e;
    single(1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, rd, lat, a, e);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL oor_lat: got %0d want 2", lat);
    end
`ifdef WB_DRAM_ERR_EN
    checks++;
    if (a !== 1'b0 || e !== 1'b1) begin
      errors++; $display("FAIL oor_err: got ack=%b err=%b want 0 1", a, e);
    end
`else
    checks++;
    if (a !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_rd: got ack=%b dat=%h want 1 0", a, rd);
    end
`endif
    single(1'b1, 32'h0000_1100, 32'h0BAD_F00D, 4'hF, rd, lat, a, e);
    single(1'b0, 32'h100, 32'h0, 4'hF, rd, lat, a, e);
    checks++;
    if (rd !== 32'hC0DE_0100) begin
      errors++; $display("FAIL oor_wr_drop: got %h want c0de0100", rd);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    seen = 1'b0;
    we = 1'b0; adr = 32'h100; sel = 4'hF; cti = 3'b000;
    cyc = 1'b1; stb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL ar_ack: got 0 want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || rdat !== 32'h0) begin
      errors++; $display("FAIL ar_drop: got ack=%b busy=%b dat=%h want 0 0 0",
                         ack, busy, rdat);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_lanes();
    test_wrap_burst();
    test_burst_gap();
    test_linear_wrap();
    test_abort();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
